// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register that sits directly after the register
// file. Each cycle it does four things:
//   - Captures the RD1/RD2 read data and the decode fields into the ID/EX
//     register.
//   - Forwards same-cycle writeback data into the operands. The register file
//     read cannot see a write that happens in the same cycle.
//   - Detects a load-use hazard against the instruction now in EX. When it
//     finds one it stalls the front end and inserts a bubble.
//   - Inserts a bubble when a taken branch/jump flush arrives from EX.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset (0 = reset)
//   flush             kill the instruction that would enter EX this cycle
//   id_*              IF/ID instruction, decode fields, RD1/RD2 read data
//   wb_we/wb_rd/wb_wd writeback port (same signals as the register file write)
//   stall_if_id       combinational: hold PC and IF/ID this cycle
//   ex_*              registered ID/EX contents
//   perf_stalls       saturating count of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  perf_stalls
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t              ex_q;
  ex_t              ex_d;
  logic             hazard;
  logic             wb_fwd1;
  logic             wb_fwd2;
  logic [CNT_W-1:0] stall_cnt;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  assign wb_fwd1 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign wb_fwd2 = wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2);

  // A load in EX delivers its data too late for a consumer in ID. The bubble
  // clears ex_mem_read, so the hazard can only last a single cycle.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                  ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_q.rd)));

  // A flush kills the stalled instruction anyway, so holding IF/ID would only
  // delay the redirect.
  assign stall_if_id = hazard && !flush && rst;

  // Capture value for the normal (non-bubble) case.
  always_comb begin
    // NOTE: default the whole struct first so that no field can be left
    // unassigned on some path and turn into a latch.
    ex_d           = '0;
    ex_d.valid     = id_valid;
    // An invalid slot may carry stale control bits; never let them reach EX.
    ex_d.reg_write = id_valid && id_reg_write;
    ex_d.mem_read  = id_valid && id_mem_read;
    ex_d.mem_write = id_valid && id_mem_write;
    ex_d.pc        = id_pc;
    ex_d.imm       = id_imm;
    ex_d.rs1_val   = wb_fwd1 ? wb_wd : id_rd1;
    ex_d.rs2_val   = wb_fwd2 ? wb_wd : id_rd2;
    ex_d.rs1       = id_rs1;
    ex_d.rs2       = id_rs2;
    ex_d.rd        = id_rd;
    ex_d.ctrl      = id_ctrl;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q      <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (hazard) begin
      ex_q <= '0;
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_ctrl      = ex_q.ctrl;
  assign perf_stalls  = stall_cnt;

endmodule
